adxl_spi_responder: RTL and testbench
=====================================

# adxl_spi_responder

Synthesizable 3-wire SPI responder that emulates the accelerometer's register file, acting as the device end of the link the configuration/readout master drives. It oversamples the SPI pins on the system clock, decodes 16-bit frames (R/W, MB, 6-bit address, 8-bit data), stores writes, serves reads on the shared SDIO line, and raises INT2 when a new X sample is loaded. It is used for loopback on the FPGA and as the device model in the master's testbench.

## Interface
- EVT_MASK, 8'hD0: INT_SOURCE bits set by a sample strobe (DATA_READY b7, b6, b4).
- DEVID_VAL, 8'hE5: value returned at address 0x00.
- iSPI_CLK  in  1  sampling clock; must be ≥8× SCLK frequency.
- iRSTN  in  1  reset, asynchronous, active-low.
- iSPI_CSN  in  1  chip select, active-low.
- iSPI_SCLK  in  1  SPI clock, mode 3 (idles high).
- SPI_SDIO  inout  1  bidirectional data; driven only during the read data phase.
- iX_DATA  in  16  new X sample, two's complement.
- iSAMPLE_STB  in  1  one-cycle strobe; loads iX_DATA.
- oG_INT2  out  1  interrupt, active-high.
- oMEASURE  out  1  POWER_CTL bit 3.
- oREG_WR_STB  out  1  one-cycle pulse per committed write.
- oREG_WR_ADDR  out  6  address of the committed write.
- oREG_WR_DATA  out  8  data of the committed write.

## Operation
- Inputs CSN, SCLK, and SDIO pass through a 2-FF synchronizer with rise/fall detection on SCLK and CSN.
- Frame bit order is MSB first. The responder samples on SCLK rising edges and shifts out on falling edges. Bit 15 = R/W (1 = read), bit 14 = MB, bits 13:8 = address, bits 7:0 = data.
- FSM states:
  - IDLE: CSN falls → ADDR.
  - ADDR: after 8 rising edges, go to RD or WR.
  - RD / WR: after 8 more rising edges, commit. If MB=1, address increments (0x3F wraps to 0x00) and the FSM stays in RD/WR. If MB=0, the FSM waits for CSN in the same state with no further effects.
  - Any state: CSN rising → IDLE, SDIO released.
- Register map (writable, reset value in parentheses): 0x24–0x29 (0x00), 0x2C BW_RATE (0x0A), 0x2D POWER_CTL (0x00), 0x2E INT_ENABLE (0x00), 0x2F INT_MAP (0x00), 0x31 DATA_FORMAT (0x00).
- Read-only registers: 0x00 DEVID, 0x30 INT_SOURCE, 0x32 DATAX0, 0x33 DATAX1.
- Unimplemented addresses read 0x00. Writes to read-only or unimplemented addresses are dropped and produce no oREG_WR_STB.
- Read byte is loaded into the output shift register on the 8th rising edge (or on the byte boundary for MB). A mid-byte register change does not affect the byte already loaded.
- iSAMPLE_STB: DATAX0/1 ← iX_DATA; INT_SOURCE |= EVT_MASK.
- Clear-on-read takes effect only after a complete 8-bit data byte has been read:
  - Reading INT_SOURCE clears bits 6:0.
  - Reading DATAX1 clears bit 7.
  - If a strobe and a clear occur in the same cycle, set wins.
- Coherence: reading DATAX0 copies DATAX1 into a hold register. The next DATAX1 read returns the hold value and clears the hold-valid flag. Without a valid hold, DATAX1 returns the live value.
- oG_INT2 = |(INT_SOURCE & INT_ENABLE & INT_MAP), registered.
- A frame aborted by CSN mid-byte does not commit its write and does not perform any clear-on-read.

## Timing
- Reset values: SDIO high-Z; oG_INT2, oMEASURE, oREG_WR_STB = 0; oREG_WR_ADDR/DATA = 0; FSM in IDLE; all registers at their map reset values.
- Latency from a pin edge to its internal event is 3 iSPI_CLK cycles.
- SDIO output enable:
  - Rises on the first SCLK fall after the 8th rising edge of a read; bit 7 is driven then.
  - Each subsequent bit is updated within 3 cycles of its SCLK fall.
  - Falls within 3 cycles of CSN rising, or of the SCLK fall after the final bit when MB=0.
- Write commit: oREG_WR_STB pulses 1 cycle after the detected 16th rising edge; the register updates in the same cycle.
- oG_INT2 follows register changes with 1-cycle latency.

## Structure
- Extend the shared spi_param.h with:
  - addresses DEVID, POWER_CTL, DATAX0 (0x32), DATAX1 (0x33);
  - reset values;
  - INT_SOURCE bit positions;
  - FSM state encodings.
- Sub-module spi_pin_sync: 2-FF synchronizer plus edge detect, instanced for SCLK and CSN; SDIO uses the synchronizer only.

## Test plan
- Write 0x2D←0x08 (frame 0x2D08) → oREG_WR_STB with addr 0x2D, data 0x08; oMEASURE=1.
- Read 0x00 (frame 0x80xx) → SDIO returns 0xE5; SDIO is high-Z outside the data phase.
- Write INT_ENABLE=0x10 and INT_MAP=0x10, then strobe iX_DATA=0xFF38 → oG_INT2=1. Read INT_SOURCE → 0xD0 and oG_INT2 falls. Read DATAX0 → 0x38. Read DATAX1 → 0xFF. INT_SOURCE then reads 0x00.
- Read DATAX0, strobe 0x0123, then read DATAX1 → 0xFF (hold value). A second DATAX1 read → 0x01.
- MB write starting at 0x3F with 2 data bytes → commits to 0x3F (dropped, no strobe) and 0x00 (dropped). MB read from 0x32 → 0x38, 0xFF.
- CSN raised after 12 bits of a write, and iRSTN asserted mid-read → no commit; SDIO high-Z; FSM in IDLE; registers at reset values after iRSTN.

Source files
------------

// File: rtl/adxl_spi_responder_pkg.sv
// Shared constants for the ADXL SPI responder: register addresses, reset values,
// INT_SOURCE bit positions, FSM state encoding and a writable-address decode helper.
package adxl_spi_responder_pkg;

  // INT_SOURCE bit positions
  localparam int unsigned INT_DATA_READY = 7;
  localparam int unsigned INT_SINGLE_TAP = 6;
  localparam int unsigned INT_ACTIVITY   = 4;

  // INT_SOURCE bits raised by a sample strobe (8'hD0)
  localparam logic [7:0] EVT_MASK =
    8'((1 << INT_DATA_READY) | (1 << INT_SINGLE_TAP) | (1 << INT_ACTIVITY));
  localparam logic [7:0] DEVID_VAL = 8'hE5;

  localparam int unsigned POWER_CTL_MEASURE = 3;

  // Register addresses
  localparam logic [5:0] ADDR_DEVID       = 6'h00;
  localparam logic [5:0] ADDR_GEN_LO      = 6'h24;
  localparam logic [5:0] ADDR_GEN_HI      = 6'h29;
  localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
  localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
  localparam logic [5:0] ADDR_INT_ENABLE  = 6'h2E;
  localparam logic [5:0] ADDR_INT_MAP     = 6'h2F;
  localparam logic [5:0] ADDR_INT_SOURCE  = 6'h30;
  localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [5:0] ADDR_DATAX0      = 6'h32;
  localparam logic [5:0] ADDR_DATAX1      = 6'h33;

  // Reset values
  localparam logic [7:0] RST_DEFAULT = 8'h00;
  localparam logic [7:0] RST_BW_RATE = 8'h0A;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StRd   = 2'd2,
    StWr   = 2'd3
  } spi_state_e;

  function automatic logic is_writable(input logic [5:0] addr);
    return ((addr >= ADDR_GEN_LO) && (addr <= ADDR_GEN_HI)) ||
           ((addr >= ADDR_BW_RATE) && (addr <= ADDR_INT_MAP)) ||
           (addr == ADDR_DATA_FORMAT);
  endfunction

endpackage

// File: rtl/adxl_spi_responder_if.sv
// SPI control pins and register-write notification bus of the ADXL responder.
//   iSPI_CSN      chip select, active-low (master -> device)
//   iSPI_SCLK     SPI clock, mode 3 (master -> device)
//   oREG_WR_STB   one-cycle pulse per committed write (device -> master side)
//   oREG_WR_ADDR  address of the committed write
//   oREG_WR_DATA  data of the committed write
interface adxl_spi_responder_if;
  logic       iSPI_CSN;
  logic       iSPI_SCLK;
  logic       oREG_WR_STB;
  logic [5:0] oREG_WR_ADDR;
  logic [7:0] oREG_WR_DATA;

  modport master (
    output iSPI_CSN, iSPI_SCLK,
    input  oREG_WR_STB, oREG_WR_ADDR, oREG_WR_DATA
  );

  modport slave (
    input  iSPI_CSN, iSPI_SCLK,
    output oREG_WR_STB, oREG_WR_ADDR, oREG_WR_DATA
  );
endinterface

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizer with registered rise/fall detection for an SPI pin.
//   iSPI_CLK  sampling clock
//   iRSTN     asynchronous active-low reset
//   iPIN      raw asynchronous pin
//   oRISE     one-cycle pulse, 3 cycles after a pin rising edge
//   oFALL     one-cycle pulse, 3 cycles after a pin falling edge
module spi_pin_sync #(
  parameter logic ResetVal = 1'b1
) (
  input  logic iSPI_CLK,
  input  logic iRSTN,
  input  logic iPIN,
  output logic oRISE,
  output logic oFALL
);

  // [1:0] synchronize, [2] holds the previous synchronized level
  logic [2:0] sync_q;
  logic       rise_q;
  logic       fall_q;

  always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
    if (!iRSTN) begin
      sync_q <= {3{ResetVal}};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], iPIN};
      rise_q <= sync_q[1] & ~sync_q[2];
      fall_q <= ~sync_q[1] & sync_q[2];
    end
  end

  assign oRISE = rise_q;
  assign oFALL = fall_q;

endmodule

// File: rtl/adxl_spi_responder.sv
// 3-wire SPI (mode 3) responder emulating the accelerometer register file.
//   iSPI_CLK     oversampling clock (>= 8x SCLK)
//   iRSTN        asynchronous active-low reset
//   bus          CSN/SCLK inputs and register-write notification outputs
//   SPI_SDIO     shared data line; driven only during the read data phase
//   iX_DATA      new X sample; iSAMPLE_STB loads it into DATAX0/1
//   oG_INT2      |(INT_SOURCE & INT_ENABLE & INT_MAP), registered
//   oMEASURE     POWER_CTL bit 3
module adxl_spi_responder
  import adxl_spi_responder_pkg::*;
(
  input  logic                       iSPI_CLK,
  input  logic                       iRSTN,
  adxl_spi_responder_if.slave        bus,
  inout  wire                        SPI_SDIO,
  input  logic [15:0]                iX_DATA,
  input  logic                       iSAMPLE_STB,
  output logic                       oG_INT2,
  output logic                       oMEASURE
);

  logic sclk_rise, sclk_fall, csn_rise, csn_fall;

  spi_pin_sync #(.ResetVal(1'b1)) u_sclk_sync (
    .iSPI_CLK (iSPI_CLK),
    .iRSTN    (iRSTN),
    .iPIN     (bus.iSPI_SCLK),
    .oRISE    (sclk_rise),
    .oFALL    (sclk_fall)
  );

  spi_pin_sync #(.ResetVal(1'b1)) u_csn_sync (
    .iSPI_CLK (iSPI_CLK),
    .iRSTN    (iRSTN),
    .iPIN     (bus.iSPI_CSN),
    .oRISE    (csn_rise),
    .oFALL    (csn_fall)
  );

  logic [1:0]  sdio_sync_q;
  spi_state_e  state_q;
  logic [2:0]  bit_cnt_q;
  logic [6:0]  rx_q;
  logic [5:0]  addr_q;
  logic        mb_q, done_q;
  logic [7:0]  tx_q;
  logic        sdio_oe_q, sdio_out_q;
  logic        wr_stb_q;
  logic [5:0]  wr_addr_q;
  logic [7:0]  wr_data_q;

  logic [7:0]  gen_q [6];
  logic [7:0]  bw_rate_q, power_ctl_q, int_enable_q, int_map_q, data_format_q;
  logic [7:0]  int_source_q, int_source_d;
  logic [15:0] datax_q;
  logic [7:0]  hold_q;
  logic        hold_vld_q;
  logic        int2_q;

  logic [7:0]  rx_byte;
  logic        byte_end, wr_commit, rd_done;
  logic [5:0]  addr_inc, rd_sel_addr;
  logic [2:0]  gen_ridx, gen_widx;
  logic [7:0]  rd_byte;

  assign rx_byte   = {rx_q, sdio_sync_q[1]};
  // A CSN rise in the same cycle aborts the byte: no commit, no clear-on-read.
  assign byte_end  = sclk_rise && (bit_cnt_q == 3'd7) && !done_q && !csn_rise;
  assign addr_inc  = addr_q + 6'd1;
  assign wr_commit = (state_q == StWr) && byte_end && is_writable(addr_q);
  assign rd_done   = (state_q == StRd) && byte_end;
  // The command byte selects the first read address, later bytes use the incremented one.
  assign rd_sel_addr = (state_q == StAddr) ? rx_byte[5:0] : addr_inc;
  assign gen_ridx    = 3'(rd_sel_addr - ADDR_GEN_LO);
  assign gen_widx    = 3'(addr_q - ADDR_GEN_LO);

  always_comb begin
    rd_byte = 8'h00;
    case (rd_sel_addr)
      ADDR_DEVID:       rd_byte = DEVID_VAL;
      ADDR_BW_RATE:     rd_byte = bw_rate_q;
      ADDR_POWER_CTL:   rd_byte = power_ctl_q;
      ADDR_INT_ENABLE:  rd_byte = int_enable_q;
      ADDR_INT_MAP:     rd_byte = int_map_q;
      ADDR_INT_SOURCE:  rd_byte = int_source_q;
      ADDR_DATA_FORMAT: rd_byte = data_format_q;
      ADDR_DATAX0:      rd_byte = datax_q[7:0];
      ADDR_DATAX1:      rd_byte = hold_vld_q ? hold_q : datax_q[15:8];
      default: begin
        if ((rd_sel_addr >= ADDR_GEN_LO) && (rd_sel_addr <= ADDR_GEN_HI)) begin
          rd_byte = gen_q[gen_ridx];
        end
      end
    endcase
  end

  always_comb begin
    int_source_d = int_source_q;
    if (rd_done && (addr_q == ADDR_INT_SOURCE)) int_source_d[6:0] = 7'h00;
    if (rd_done && (addr_q == ADDR_DATAX1))     int_source_d[INT_DATA_READY] = 1'b0;
    // Set after clear so a coincident strobe wins
    if (iSAMPLE_STB) int_source_d = int_source_d | EVT_MASK;
  end

  // Frame FSM, shifter and SDIO driver
  always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
    if (!iRSTN) begin
      sdio_sync_q <= 2'b11;
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 7'd0;
      addr_q      <= 6'd0;
      mb_q        <= 1'b0;
      done_q      <= 1'b0;
      tx_q        <= 8'd0;
      sdio_oe_q   <= 1'b0;
      sdio_out_q  <= 1'b0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= 6'd0;
      wr_data_q   <= 8'd0;
    end else begin
      sdio_sync_q <= {sdio_sync_q[0], SPI_SDIO};
      wr_stb_q    <= wr_commit;
      if (wr_commit) begin
        wr_addr_q <= addr_q;
        wr_data_q <= rx_byte;
      end
      if (csn_rise) begin
        state_q   <= StIdle;
        sdio_oe_q <= 1'b0;
      end else begin
        if (sclk_rise) begin
          rx_q      <= rx_byte[6:0];
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end
        unique case (state_q)
          StIdle: begin
            if (csn_fall) begin
              state_q   <= StAddr;
              bit_cnt_q <= 3'd0;
              done_q    <= 1'b0;
            end
          end
          StAddr: begin
            if (sclk_rise && (bit_cnt_q == 3'd7)) begin
              mb_q   <= rx_byte[6];
              addr_q <= rx_byte[5:0];
              if (rx_byte[7]) begin
                state_q <= StRd;
                tx_q    <= rd_byte;
              end else begin
                state_q <= StWr;
              end
            end
          end
          StRd: begin
            if (byte_end) begin
              if (mb_q) begin
                addr_q <= addr_inc;
                tx_q   <= rd_byte;
              end else begin
                done_q <= 1'b1;
              end
            end
            if (sclk_fall) begin
              if (done_q) begin
                sdio_oe_q <= 1'b0;
              end else begin
                sdio_oe_q  <= 1'b1;
                sdio_out_q <= tx_q[7];
                tx_q       <= {tx_q[6:0], 1'b0};
              end
            end
          end
          StWr: begin
            if (byte_end) begin
              if (mb_q) addr_q <= addr_inc;
              else      done_q <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Register file
  always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
    if (!iRSTN) begin
      for (int i = 0; i < 6; i++) gen_q[i] <= RST_DEFAULT;
      bw_rate_q     <= RST_BW_RATE;
      power_ctl_q   <= RST_DEFAULT;
      int_enable_q  <= RST_DEFAULT;
      int_map_q     <= RST_DEFAULT;
      data_format_q <= RST_DEFAULT;
      int_source_q  <= RST_DEFAULT;
      datax_q       <= 16'h0000;
      hold_q        <= RST_DEFAULT;
      hold_vld_q    <= 1'b0;
      int2_q        <= 1'b0;
    end else begin
      if (wr_commit) begin
        case (addr_q)
          ADDR_BW_RATE:     bw_rate_q     <= rx_byte;
          ADDR_POWER_CTL:   power_ctl_q   <= rx_byte;
          ADDR_INT_ENABLE:  int_enable_q  <= rx_byte;
          ADDR_INT_MAP:     int_map_q     <= rx_byte;
          ADDR_DATA_FORMAT: data_format_q <= rx_byte;
          default:          gen_q[gen_widx] <= rx_byte;
        endcase
      end
      if (iSAMPLE_STB) datax_q <= iX_DATA;
      int_source_q <= int_source_d;
      // DATAX0 read snapshots the high byte so a following DATAX1 read is coherent
      if (rd_done && (addr_q == ADDR_DATAX0)) begin
        hold_q     <= datax_q[15:8];
        hold_vld_q <= 1'b1;
      end else if (rd_done && (addr_q == ADDR_DATAX1)) begin
        hold_vld_q <= 1'b0;
      end
      int2_q <= |(int_source_q & int_enable_q & int_map_q);
    end
  end

  assign SPI_SDIO         = sdio_oe_q ? sdio_out_q : 1'bz;
  assign bus.oREG_WR_STB  = wr_stb_q;
  assign bus.oREG_WR_ADDR = wr_addr_q;
  assign bus.oREG_WR_DATA = wr_data_q;
  assign oG_INT2          = int2_q;
  assign oMEASURE         = power_ctl_q[POWER_CTL_MEASURE];

endmodule

// File: tb/tb_adxl_spi_responder.sv
// Scoreboard bench for adxl_spi_responder: expected read bytes and write commits are
// queued from a small register model as frames are issued and compared as the DUT
// produces them.
module tb_adxl_spi_responder;
  import adxl_spi_responder_pkg::*;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] x_data;
  logic        sample_stb;
  logic        g_int2, measure;
  logic        tb_oe, tb_do;
  wire         sdio;

  assign sdio = tb_oe ? tb_do : 1'bz;

  adxl_spi_responder_if bus ();

  adxl_spi_responder dut (
    .iSPI_CLK    (clk),
    .iRSTN       (rstn),
    .bus         (bus),
    .SPI_SDIO    (sdio),
    .iX_DATA     (x_data),
    .iSAMPLE_STB (sample_stb),
    .oG_INT2     (g_int2),
    .oMEASURE    (measure)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  logic [7:0]  rd_exp_q [$];
  logic [13:0] wr_exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Register model
  logic [7:0]  m_reg [64];
  logic [7:0]  m_isrc;
  logic [15:0] m_x;
  logic [7:0]  m_hold;
  logic        m_hold_v;

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_reg[i] = 8'h00;
    m_reg[6'h2C] = 8'h0A;
    m_isrc = 8'h00;
    m_x = 16'h0000;
    m_hold = 8'h00;
    m_hold_v = 1'b0;
  endtask

  function automatic logic tb_writable(input logic [5:0] a);
    return (a inside {[6'h24:6'h29], [6'h2C:6'h2F], 6'h31});
  endfunction

  function automatic logic [7:0] model_read(input logic [5:0] a);
    case (a)
      6'h00:   return 8'hE5;
      6'h30:   return m_isrc;
      6'h32:   return m_x[7:0];
      6'h33:   return m_hold_v ? m_hold : m_x[15:8];
      default: return tb_writable(a) ? m_reg[a] : 8'h00;
    endcase
  endfunction

  task automatic model_done(input logic [5:0] a);
    if (a == 6'h30) m_isrc = m_isrc & 8'h80;
    if (a == 6'h32) begin
      m_hold = m_x[15:8];
      m_hold_v = 1'b1;
    end
    if (a == 6'h33) begin
      m_hold_v = 1'b0;
      m_isrc = m_isrc & 8'h7F;
    end
  endtask

  function automatic logic model_int2();
    return |(m_isrc & m_reg[6'h2E] & m_reg[6'h2F]);
  endfunction

  // Write-commit scoreboard
  always @(negedge clk) begin
    if (rstn && bus.oREG_WR_STB) begin
      if (wr_exp_q.size() == 0) begin
        check_eq("wr_unexpected_stb", 32'(bus.oREG_WR_STB), 32'd0);
      end else begin
        check_eq("wr_commit", {18'd0, bus.oREG_WR_ADDR, bus.oREG_WR_DATA},
                 {18'd0, wr_exp_q.pop_front()});
      end
    end
  end

  // One frame: nb data bytes; abort_at > 0 ends the frame after that many SCLK rises,
  // with a reset pulse first when abort_rst is set.
  task automatic spi_xfer(input logic rd, input logic mb, input logic [5:0] a, input int nb,
                          input logic [31:0] wd, input int abort_at, input logic abort_rst);
    logic [15:0] cmd;
    logic [5:0]  cur;
    logic [7:0]  cap;
    logic [7:0]  b8;
    cmd = {rd, mb, a, 8'h00};
    cap = 8'h00;
    if (abort_at == 0) begin
      cur = a;
      for (int i = 0; i < nb; i++) begin
        if (rd) begin
          rd_exp_q.push_back(model_read(cur));
          if (i > 0) model_done(cur - 6'd1);
        end else begin
          b8 = wd[31-8*i -: 8];
          if (tb_writable(cur)) begin
            m_reg[cur] = b8;
            wr_exp_q.push_back({cur, b8});
          end
        end
        cur = cur + 6'd1;
      end
      if (rd) model_done(cur - 6'd1);
    end
    bus.iSPI_CSN = 1'b0;
    tick(HALF);
    for (int b = 0; b < 8 * (nb + 1); b++) begin
      bus.iSPI_SCLK = 1'b0;
      if (rd && b >= 8) begin
        tb_oe = 1'b0;
      end else begin
        tb_oe = 1'b1;
        if (b < 8) tb_do = cmd[15-b];
        else       tb_do = wd[39-b];
      end
      tick(HALF);
      if (b == 7) check_eq("sdio_oe_cmd", 32'(dut.sdio_oe_q), 32'd0);
      if (rd && b >= 8) begin
        cap = {cap[6:0], sdio};
        if (b == 8) check_eq("sdio_oe_data", 32'(dut.sdio_oe_q), 32'd1);
        if (b % 8 == 7) begin
          check_eq("rd_exp_avail", 32'(rd_exp_q.size() != 0), 32'd1);
          if (rd_exp_q.size() != 0) check_eq("rd_byte", 32'(cap), 32'(rd_exp_q.pop_front()));
        end
      end
      bus.iSPI_SCLK = 1'b1;
      tick(HALF);
      if (abort_at != 0 && b + 1 == abort_at) begin
        if (abort_rst) begin
          rstn = 1'b0;
          tick(2);
          check_eq("rst_sdio_oe", 32'(dut.sdio_oe_q), 32'd0);
          model_reset();
          rstn = 1'b1;
          tick(2);
        end
        break;
      end
    end
    bus.iSPI_CSN = 1'b1;
    tb_oe = 1'b0;
    tick(HALF);
    check_eq("sdio_oe_idle", 32'(dut.sdio_oe_q), 32'd0);
    check_eq("state_idle", 32'(dut.state_q), 32'(StIdle));
    check_eq("int2", 32'(g_int2), 32'(model_int2()));
    check_eq("measure", 32'(measure), 32'(m_reg[6'h2D][3]));
    check_eq("wr_pending", 32'(wr_exp_q.size()), 32'd0);
  endtask

  task automatic strobe_x(input logic [15:0] x);
    x_data = x;
    sample_stb = 1'b1;
    tick(1);
    sample_stb = 1'b0;
    m_x = x;
    m_isrc = m_isrc | 8'hD0;
    tick(2);
    check_eq("int2_stb", 32'(g_int2), 32'(model_int2()));
  endtask

  initial begin
    bus.iSPI_CSN = 1'b1;
    bus.iSPI_SCLK = 1'b1;
    tb_oe = 1'b0;
    tb_do = 1'b0;
    x_data = 16'h0000;
    sample_stb = 1'b0;
    model_reset();
    tick(3);
    check_eq("rst_int2", 32'(g_int2), 32'd0);
    check_eq("rst_measure", 32'(measure), 32'd0);
    check_eq("rst_wr_stb", 32'(bus.oREG_WR_STB), 32'd0);
    check_eq("rst_wr_addr", 32'(bus.oREG_WR_ADDR), 32'd0);
    check_eq("rst_wr_data", 32'(bus.oREG_WR_DATA), 32'd0);
    check_eq("rst_sdio_oe0", 32'(dut.sdio_oe_q), 32'd0);
    rstn = 1'b1;
    tick(3);

    spi_xfer(1'b0, 1'b0, 6'h2D, 1, 32'h0800_0000, 0, 1'b0);   // POWER_CTL <- 0x08
    spi_xfer(1'b1, 1'b0, 6'h00, 1, 32'h0, 0, 1'b0);           // DEVID

    spi_xfer(1'b0, 1'b0, 6'h2E, 1, 32'h1000_0000, 0, 1'b0);
    spi_xfer(1'b0, 1'b0, 6'h2F, 1, 32'h1000_0000, 0, 1'b0);
    strobe_x(16'hFF38);
    spi_xfer(1'b1, 1'b0, 6'h30, 1, 32'h0, 0, 1'b0);
    spi_xfer(1'b1, 1'b0, 6'h32, 1, 32'h0, 0, 1'b0);
    spi_xfer(1'b1, 1'b0, 6'h33, 1, 32'h0, 0, 1'b0);
    spi_xfer(1'b1, 1'b0, 6'h30, 1, 32'h0, 0, 1'b0);

    spi_xfer(1'b1, 1'b1, 6'h32, 2, 32'h0, 0, 1'b0);           // MB read DATAX0/1

    spi_xfer(1'b1, 1'b0, 6'h32, 1, 32'h0, 0, 1'b0);           // hold coherence
    strobe_x(16'h0123);
    spi_xfer(1'b1, 1'b0, 6'h33, 1, 32'h0, 0, 1'b0);
    spi_xfer(1'b1, 1'b0, 6'h33, 1, 32'h0, 0, 1'b0);

    spi_xfer(1'b0, 1'b1, 6'h3F, 2, 32'hAA55_0000, 0, 1'b0);   // wraps, all dropped
    spi_xfer(1'b1, 1'b0, 6'h00, 1, 32'h0, 0, 1'b0);
    spi_xfer(1'b0, 1'b1, 6'h28, 3, 32'h5AC3_7700, 0, 1'b0);   // 0x2A dropped
    spi_xfer(1'b1, 1'b1, 6'h28, 3, 32'h0, 0, 1'b0);

    spi_xfer(1'b0, 1'b0, 6'h2C, 1, 32'h0F00_0000, 0, 1'b0);
    spi_xfer(1'b0, 1'b0, 6'h2C, 1, 32'h5500_0000, 12, 1'b0);  // CSN abort mid-data
    spi_xfer(1'b1, 1'b0, 6'h2C, 1, 32'h0, 0, 1'b0);

    spi_xfer(1'b1, 1'b0, 6'h2C, 1, 32'h0, 12, 1'b1);          // reset mid-read
    spi_xfer(1'b1, 1'b0, 6'h2C, 1, 32'h0, 0, 1'b0);
    spi_xfer(1'b1, 1'b0, 6'h2D, 1, 32'h0, 0, 1'b0);

    check_eq("rd_left", 32'(rd_exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
